// File: rtl/booth_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : booth_seq_ctrl
// Purpose  : Sequencer for a radix-2 Booth multiplier datapath (A, Q/Q-1, M).
// Revision : 1.0 - initial release
// ============================================================================
module booth_seq_ctrl #(
  parameter int DATA_WIDTH = 4,
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           booth_bits,
  output logic                 load_default,
  output logic                 acc_we,
  output logic                 alu_sub,
  output logic                 shift_en,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] C_ITERS = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] C_LAST  = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_EVAL  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] w_count_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // booth_bits is only looked at inside EVAL so an undriven operand bus
  // outside that state can never reach the strobes.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    load_default = 1'b0;
    acc_we       = 1'b0;
    alu_sub      = 1'b0;
    shift_en     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_INIT;
      end
      S_INIT: begin
        load_default = 1'b1;
        busy         = 1'b1;
        w_count_next = C_ITERS;
        w_state_next = S_EVAL;
      end
      S_EVAL: begin
        busy = 1'b1;
        case (booth_bits)
          2'b01:   acc_we = 1'b1;
          2'b10: begin
            acc_we  = 1'b1;
            alu_sub = 1'b1;
          end
          default: ;
        endcase
        w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        shift_en     = 1'b1;
        busy         = 1'b1;
        w_count_next = r_count - C_LAST;
        w_state_next = (r_count == C_LAST) ? S_DONE : S_EVAL;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_seq_ctrl
// Purpose  : Directed bench for booth_seq_ctrl with a 4-bit Booth datapath in loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] booth_bits;
  logic       load_default, acc_we, alu_sub, shift_en, busy, done;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  booth_seq_ctrl #(.DATA_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .booth_bits(booth_bits),
    .load_default(load_default), .acc_we(acc_we), .alu_sub(alu_sub),
    .shift_en(shift_en), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  // Booth datapath: A, Q, Q-1, M driven by the controller strobes
  logic [3:0] dp_a = '0, dp_q = '0, dp_m = '0;
  logic       dp_q1 = 1'b0;
  logic [3:0] op_mc, op_mp;
  logic       force_x;

  always @(posedge clk) begin
    if (load_default) begin
      dp_a <= '0; dp_q <= op_mp; dp_q1 <= 1'b0; dp_m <= op_mc;
    end else if (acc_we) begin
      dp_a <= alu_sub ? dp_a - dp_m : dp_a + dp_m;
    end else if (shift_en) begin
      {dp_a, dp_q, dp_q1} <= {dp_a[3], dp_a, dp_q};
    end
  end

  assign booth_bits = force_x ? 2'bxx : {dp_q[0], dp_q1};

  int n_done = 0;
  int n_viol = 0;
  always @(negedge clk) begin
    if (done) n_done++;
    if ((32'(load_default) + 32'(acc_we) + 32'(shift_en)) > 1) n_viol++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int         done_cyc, nshift, nload;
  logic [3:0] acc_pat, sub_pat;
  logic [11:0] cnt_pat;
  logic [7:0] prod;
  logic [2:0] cnt_done;
  logic       ld_at1;

  task automatic do_mul(input logic [3:0] mc, input logic [3:0] mp, input int s1, input int s2);
    op_mc = mc; op_mp = mp;
    acc_pat = '0; sub_pat = '0; cnt_pat = '0; prod = '0; cnt_done = '1;
    nshift = 0; nload = 0; done_cyc = 0; ld_at1 = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 1) ld_at1 = load_default;
      if (load_default) nload++;
      if (shift_en) nshift++;
      if (busy && !load_default && !shift_en) begin
        acc_pat = {acc_pat[2:0], acc_we};
        sub_pat = {sub_pat[2:0], alu_sub};
        cnt_pat = {cnt_pat[8:0], count};
      end
      if (done) begin
        done_cyc = c; prod = {dp_a, dp_q}; cnt_done = count;
        break;
      end
      start = (c == s1) || (c == s2);
      tick;
    end
    start = 1'b0;
    check("done_seen", 32'(done_cyc != 0), 32'd1);
  endtask

  int base_done;
  int nd, nl;
  int d_c[3];
  int ld_c[3];

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    // reset with start held high and booth_bits undriven
    rst = 1'b1; start = 1'b1; force_x = 1'b1; op_mc = '0; op_mp = '0;
    tick; tick;
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_load",  32'(load_default), 32'd0);
    check("rst_accwe", 32'(acc_we), 32'd0);
    check("rst_sub",   32'(alu_sub), 32'd0);
    check("rst_shift", 32'(shift_en), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    rst = 1'b0; force_x = 1'b0;

    // 3 x 6
    do_mul(4'd3, 4'd6, 0, 0);
    check("init_after_rst", 32'(ld_at1), 32'd1);
    check("m36_done_cyc", 32'(done_cyc), 32'd10);
    check("m36_acc_pat",  32'(acc_pat), 32'b0101);
    check("m36_sub_pat",  32'(sub_pat), 32'b0100);
    check("m36_product",  32'(prod), 32'h12);
    check("m36_done_busy", 32'(busy), 32'd0);
    tick;
    check("m36_post_done", 32'(done), 32'd0);
    check("m36_post_busy", 32'(busy), 32'd0);

    // -3 x -2
    force_x = 1'b1;
    tick;
    check("idle_x_accwe", 32'(acc_we), 32'd0);
    force_x = 1'b0;
    do_mul(4'hD, 4'hE, 0, 0);
    check("neg_done_cyc", 32'(done_cyc), 32'd10);
    check("neg_product",  32'(prod), 32'h06);
    check("neg_nshift",   32'(nshift), 32'd4);
    check("neg_nload",    32'(nload), 32'd1);
    tick;

    // 5 x 2 with start pulses at cycles 3 and 7
    base_done = n_done;
    do_mul(4'd5, 4'd2, 3, 7);
    check("busy_done_cyc", 32'(done_cyc), 32'd10);
    check("busy_cnt_seq",  32'(cnt_pat), 32'h8D1);
    check("busy_cnt_done", 32'(cnt_done), 32'd0);
    check("busy_product",  32'(prod), 32'h0A);
    for (int i = 0; i < 12; i++) tick;
    check("busy_single_done", 32'(n_done - base_done), 32'd1);
    check("busy_no_restart",  32'(busy), 32'd0);

    // reset in the second SHIFT
    op_mc = 4'd7; op_mp = 4'hF;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    check("mid_in_shift", 32'(shift_en), 32'd1);
    check("mid_cnt_before", 32'(count), 32'd3);
    base_done = n_done;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_busy",  32'(busy), 32'd0);
    check("mid_count", 32'(count), 32'd0);
    check("mid_shift", 32'(shift_en), 32'd0);
    check("mid_done",  32'(done), 32'd0);
    for (int i = 0; i < 12; i++) tick;
    check("mid_no_done", 32'(n_done - base_done), 32'd0);
    do_mul(4'd7, 4'hF, 0, 0);
    check("m7n1_done_cyc", 32'(done_cyc), 32'd10);
    check("m7n1_product",  32'(prod), 32'hF9);
    tick;

    // back-to-back with start held high
    op_mc = 4'd2; op_mp = 4'd3;
    nd = 0; nl = 0;
    start = 1'b1;
    tick;
    for (int c = 1; c <= 60; c++) begin
      if (load_default) begin
        if (nl < 3) ld_c[nl] = c;
        nl++;
      end
      if (done) begin
        if (nd < 3) d_c[nd] = c;
        nd++;
        if (nd == 3) begin
          start = 1'b0;
          break;
        end
      end
      tick;
    end
    start = 1'b0;
    check("b2b_ndone", 32'(nd), 32'd3);
    check("b2b_nload", 32'(nl), 32'd3);
    check("b2b_first_done", 32'(d_c[0]), 32'd10);
    check("b2b_gap1", 32'(d_c[1] - d_c[0]), 32'd11);
    check("b2b_gap2", 32'(d_c[2] - d_c[1]), 32'd11);
    check("b2b_ld0", 32'(ld_c[0]), 32'd1);
    check("b2b_ld1", 32'(ld_c[1]), 32'd12);
    check("b2b_ld2", 32'(ld_c[2]), 32'd23);
    check("b2b_product", 32'({dp_a, dp_q}), 32'h06);
    tick; tick;
    check("b2b_idle", 32'(busy), 32'd0);

    check("strobe_exclusive", 32'(n_viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/booth_seq_ctrl.md
Name: booth_seq_ctrl

Overview:
- FSM controller that sequences the radix-2 Booth multiplier datapath: the A accumulator, the Q/Q-1 multiplier registers and the M multiplicand register.
- Drives the register load-default, write-enable, add/subtract and arithmetic-shift strobes, and counts DATA_WIDTH iterations.
- Reports busy while a multiply is running and pulses done when the product in {A,Q} is final.
- Sits between the multiplier top-level handshake (start/done) and the register/ALU datapath.

Parameters:
DATA_WIDTH, 4, operand width N; number of Booth iterations.
CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width; derived localparam, not overridden.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a new multiply; sampled only in IDLE.
booth_bits  input  2  {Q[0], Q_-1} from datapath; sampled only in EVAL.
load_default  output  1  datapath init: A<=0, Q<=multiplier, Q_-1<=0, M<=multiplicand.
acc_we  output  1  write ALU result into A this cycle.
alu_sub  output  1  1: A-M, 0: A+M; meaningful only when acc_we=1.
shift_en  output  1  arithmetic right shift of {A,Q,Q_-1} by one.
busy  output  1  high in INIT, EVAL, SHIFT.
done  output  1  one-cycle pulse; product valid in {A,Q} during this cycle.
count  output  CNT_WIDTH  remaining iterations.

Behaviour:
- Reset: this block has one clock and a synchronous, active-high reset. When rst=1 at a clk edge: state<=IDLE, count<=0. All outputs are then 0 (all strobes, busy, done, count). rst has priority over every other input.
- States: IDLE, INIT, EVAL, SHIFT, DONE (binary or one-hot encoding).
- IDLE: all strobes 0. start=1 -> INIT; otherwise stay in IDLE.
- INIT (1 cycle): load_default=1; count<=DATA_WIDTH; -> EVAL.
- EVAL (1 cycle): decode booth_bits.
  - 2'b01: acc_we=1, alu_sub=0 (add).
  - 2'b10: acc_we=1, alu_sub=1 (subtract).
  - 2'b00 or 2'b11: acc_we=0, alu_sub=0.
  - Always -> SHIFT.
- SHIFT (1 cycle): shift_en=1; count<=count-1.
  - count==1 -> DONE; otherwise -> EVAL.
- DONE (1 cycle): done=1, busy=0; -> IDLE unconditionally.
- Output decode: load_default, shift_en, busy and done decode from state only. acc_we and alu_sub decode from state plus booth_bits (Mealy, EVAL only). At most one of load_default/acc_we/shift_en is high in any cycle.
- Latency: start sampled at edge E0 gives INIT in cycle 1, EVAL/SHIFT pairs in cycles 2..2N+1, and DONE in cycle 2N+2. For N=4, done is high 10 cycles after the start edge. The next start is accepted in the cycle after DONE, giving back-to-back throughput of one multiply per 2N+3 cycles.
- start while busy or in DONE: ignored; no queuing.
- start held high continuously: a new multiply begins on each return to IDLE.
- booth_bits: ignored outside EVAL; X on booth_bits outside EVAL must not propagate to outputs.
- count: never wraps; it is only decremented in SHIFT, and SHIFT with count==1 always exits to DONE. count holds 0 from DONE onward and is reloaded only in INIT.
- Reset mid-operation (any state): IDLE at the next edge, strobes 0, count 0. The datapath contents become don't-care and are not cleared by this block.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 -> state IDLE, all outputs 0, count=0. After rst=0, start is accepted and INIT appears the following cycle.
- Single multiply, N=4, 3 x 6 (M=0011, Q=0110), with a datapath model in loop.
  - booth_bits sequence: 00, 10, 11, 01.
  - Controller response: acc_we pattern 0,1,0,1 and alu_sub 0,1,0,0.
  - done pulses 10 cycles after start; {A,Q}=0001_0010 (18).
- Signed operands: M=-3 (1101), Q=-2 (1110) -> done at cycle 10; {A,Q}=0000_0110 (+6). Exactly 4 shift_en pulses and 1 load_default pulse.
- Start while busy: pulse start again at cycles 3 and 7 of a multiply. Required: no restart; count sequence 4,3,2,1,0 uninterrupted; a single done pulse.
- Reset mid-op: assert rst in the 2nd SHIFT -> next cycle IDLE, busy=0, count=0, no done. A fresh 7 x -1 multiply then completes correctly with {A,Q}=1111_1001 (-7).
- Back-to-back: start tied high for 3 multiplies -> done pulses are exactly 11 cycles apart (N=4). load_default is asserted only in each INIT.
